// File: rtl/fpu_key_pkg.sv
// Shared definitions for order-preserving float keys.
// A key is an IEEE-754 single remapped so that unsigned integer compare
// gives the same order as float compare. Holds the key layout, the
// reserved key values and the key-to-float decode used by fkey_dec.
package fpu_key_pkg;

   // Key produced for +0, -0 and all denormals.
   localparam logic [31:0] KEY_ZERO            = 32'h8000_0000;
   // Exponent field that no negative float can produce (it would be ~0x00).
   localparam logic [7:0]  KEY_EXP_ILLEGAL_NEG = 8'hFF;

   typedef struct packed {
      logic        s;
      logic [7:0]  e;
      logic [22:0] m;
   } fkey_t;

   typedef struct packed {
      logic        illegal;
      logic [31:0] data;
   } fdec_t;

   // Key to float. Malformed keys decode to 0x00000000 with illegal set.
   function automatic fdec_t fkey_decode(input fkey_t key);
      fdec_t r;
      r.illegal = 1'b0;
      r.data    = 32'h0000_0000;
      if (key.s) begin
         if (key.e != 8'h00) begin
            r.data = {1'b0, key.e, key.m};
         end else begin
            // Only the canonical zero key is legal with a zero exponent;
            // the sign of zero cannot be recovered, so it decodes to +0.
            r.illegal = (key != KEY_ZERO);
         end
      end else begin
         if (key.e == KEY_EXP_ILLEGAL_NEG) begin
            r.illegal = 1'b1;
         end else begin
            r.data = {1'b1, ~key.e, ~key.m};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fkey_dec_stage.sv
// Generic valid/ready register slice of width W.
// Loads whenever it is empty or its content is leaving this cycle, so a
// chain of these slices runs at one word per clock. Data only changes on
// an actual transfer in, so the last word stays visible after draining.
module fkey_dec_stage #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic         v_q, v_d;
   logic [W-1:0] data_q, data_d;

   assign in_ready_o  = ~v_q | out_ready_i;
   assign out_valid_o = v_q;
   assign out_data_o  = data_q;

   // Next state: take the incoming word when there is room, else hold.
   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      if (in_ready_o) begin
         v_d = in_valid_i;
         if (in_valid_i) begin
            data_d = in_data_i;
         end
      end
   end

   // Slice registers; reset empties the slice and clears the data.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v_q    <= 1'b0;
         data_q <= '0;
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/fkey_dec.sv
// fkey_dec: streaming decoder from sortable float keys to IEEE-754 singles.
// Stage 1 holds the raw key, stage 2 holds the decoded word and the
// illegal flag. Optional feature macro: FKEY_DEC_ILLEGAL_CNT_EN enables a
// saturating count of illegal words delivered; without it illegal_cnt is 0.
//
// Handshake: a word moves across an interface on a rising clk edge where
// valid and ready are both high. A producer holds its data stable while
// valid is high and ready is low; ready may depend combinationally on the
// downstream ready (in_ready follows out_ready in the same cycle).
module fkey_dec
   import fpu_key_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_illegal,
   output logic [15:0] illegal_cnt
);

   logic        s1_v;
   logic        s2_ready;
   logic [31:0] s1_key;
   fdec_t       s1_dec;
   fdec_t       s2_word;

   fkey_dec_stage #(.W(32)) u_stage1 (
      .clk         (clk),
      .rstn        (rstn),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_key),
      .out_valid_o (s1_v),
      .out_ready_i (s2_ready),
      .out_data_o  (s1_key)
   );

   assign s1_dec = fkey_decode(fkey_t'(s1_key));

   fkey_dec_stage #(.W(33)) u_stage2 (
      .clk         (clk),
      .rstn        (rstn),
      .in_valid_i  (s1_v),
      .in_ready_o  (s2_ready),
      .in_data_i   (s1_dec),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (s2_word)
   );

   assign out_data    = s2_word.data;
   assign out_illegal = s2_word.illegal;

`ifdef FKEY_DEC_ILLEGAL_CNT_EN
   logic [15:0] illegal_cnt_q, illegal_cnt_d;

   // Count delivered illegal words, sticking at the maximum.
   always_comb begin
      illegal_cnt_d = illegal_cnt_q;
      if (out_valid && out_ready && out_illegal && (illegal_cnt_q != 16'hFFFF)) begin
         illegal_cnt_d = illegal_cnt_q + 16'd1;
      end
   end

   // Counter register; only reset clears it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         illegal_cnt_q <= 16'h0000;
      end else begin
         illegal_cnt_q <= illegal_cnt_d;
      end
   end

   assign illegal_cnt = illegal_cnt_q;
`else
   assign illegal_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fkey_dec.sv
// Self-checking bench for fkey_dec. Honours FKEY_DEC_ILLEGAL_CNT_EN when
// the same define is given to the build.
module tb_fkey_dec;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_key;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_illegal;
   logic [15:0] illegal_cnt;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [32:0] exp_q[$];
   logic [15:0] exp_cnt = 16'h0000;
   logic        prev_stall = 1'b0;
   logic [32:0] prev_word = '0;
   logic        rnd_done = 1'b0;

   fkey_dec dut (
      .clk         (clk),
      .rstn        (rstn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_key      (in_key),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_illegal (out_illegal),
      .illegal_cnt (illegal_cnt)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Float to key, written from the key format description.
   function automatic logic [31:0] enc(input logic [31:0] f);
      if (f[30:23] == 8'h00) return 32'h8000_0000;
      else if (!f[31])       return {1'b1, f[30:0]};
      else                   return {1'b0, ~f[30:0]};
   endfunction

   function automatic logic [15:0] cnt_model();
`ifdef FKEY_DEC_ILLEGAL_CNT_EN
      return exp_cnt;
`else
      return 16'h0000;
`endif
   endfunction

   // Drive one key, hold until accepted, push its expected result.
   task automatic send(input logic [31:0] key, input logic [32:0] exp);
      int n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_key   = key;
      @(negedge clk);
      while (!in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("send_timeout", in_ready, 1'b1);
      else exp_q.push_back(exp);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 33'(exp_q.size()), 33'd0);
      @(posedge clk); #1;
   endtask

   // Scoreboard monitor: compare delivered words and check stall stability.
   always @(negedge clk) begin
      logic [32:0] e;
      if (!rstn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", {out_illegal, out_data}, prev_word);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", out_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("out_word", {out_illegal, out_data}, e);
               if (e[32] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            end
         end
         prev_stall = out_valid & ~out_ready;
         prev_word  = {out_illegal, out_data};
      end
   end

   initial begin
      logic [31:0] f;
      rstn      = 1'b1;
      in_valid  = 1'b0;
      in_key    = 32'h0;
      out_ready = 1'b0;

      // Asynchronous reset before any clock edge
      #1 rstn = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_illegal", out_illegal, 1'b0);
      chk("rst_illegal_cnt", illegal_cnt, 16'h0);
      chk("rst_in_ready", in_ready, 1'b1);
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;

      // Latency and back-to-back decode
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_key    = 32'hBF80_0000;
      @(negedge clk);
      chk("lat_in_ready", in_ready, 1'b1);
      exp_q.push_back({1'b0, 32'h3F80_0000});
      @(posedge clk); #1;
      in_key = 32'h407F_FFFF;
      @(negedge clk);
      chk("lat_edge1_valid", out_valid, 1'b0);
      exp_q.push_back({1'b0, 32'hBF80_0000});
      @(posedge clk); #1;
      in_key = 32'h8000_0000;
      @(negedge clk);
      chk("lat_edge2_valid", out_valid, 1'b1);
      exp_q.push_back({1'b0, 32'h0000_0000});
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("stream_word2_valid", out_valid, 1'b1);
      @(negedge clk);
      chk("stream_word3_valid", out_valid, 1'b1);
      drain();

      // Illegal keys
      send(32'h8000_0001, {1'b1, 32'h0});
      send(32'h7F80_0000, {1'b1, 32'h0});
      idle();
      drain();
      chk("illegal_cnt_after_2", illegal_cnt, cnt_model());

      // Backpressure: fill both stages, stall, then reopen
      out_ready = 1'b0;
      send(enc(32'h4049_0FDB), {1'b0, 32'h4049_0FDB});
      send(enc(32'hC2C8_0000), {1'b0, 32'hC2C8_0000});
      @(posedge clk); #1;
      in_key = enc(32'h3DCC_CCCD);
      @(negedge clk);
      chk("bp_in_ready_low0", in_ready, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("bp_in_ready_low", in_ready, 1'b0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_reopen", in_ready, 1'b1);
      exp_q.push_back({1'b0, 32'h3DCC_CCCD});
      send(enc(32'hFF7F_FFFF), {1'b0, 32'hFF7F_FFFF});
      idle();
      drain();

      // Random interleaved traffic
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               if ($urandom_range(0, 15) == 0) idle();
               f[31] = 1'($urandom_range(0, 1));
               f[30:23] = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 254));
               f[22:0] = ($urandom_range(0, 7) == 0) ? 23'h0 : 23'($urandom);
               send(enc(f), {1'b0, (f[30:23] == 8'h00) ? 32'h0 : f});
            end
            idle();
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 15) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();
      chk("illegal_cnt_after_rand", illegal_cnt, cnt_model());

      // Reset with both stages full
      out_ready = 1'b0;
      send(enc(32'h3F80_0000), {1'b0, 32'h3F80_0000});
      send(32'h8000_0003, {1'b1, 32'h0});
      idle();
      chk("full_in_ready", in_ready, 1'b0);
      chk("full_out_valid", out_valid, 1'b1);
      #2 rstn = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_illegal_cnt", illegal_cnt, 16'h0);
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_out_data", out_data, 32'h0);
      exp_q.delete();
      exp_cnt = 16'h0000;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rstn = 1'b1;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_no_stale", out_valid, 1'b0);
         chk("post_rst_in_ready", in_ready, 1'b1);
      end

`ifdef FKEY_DEC_ILLEGAL_CNT_EN
      // Saturation of the illegal counter
      for (int i = 0; i < 32'h10000; i++) begin
         send(32'h7FFF_FFFF, {1'b1, 32'h0});
      end
      idle();
      drain();
      chk("illegal_cnt_sat", illegal_cnt, 16'hFFFF);
      chk("illegal_cnt_model", illegal_cnt, cnt_model());
`else
      send(32'h7FFF_FFFF, {1'b1, 32'h0});
      idle();
      drain();
      chk("illegal_cnt_off", illegal_cnt, 16'h0000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
